// File: rtl/secuenciador_pkg.sv
// secuenciador_pkg
// Shared definitions for the boot/run sequencer: the FSM state encoding,
// stream framing constants and a small state-classification helper.
package secuenciador_pkg;

  // Sequencer states; the encoding is fixed so it can be probed externally.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN    = 3'd1,
    ST_BYTES  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RUN    = 3'd4,
    ST_HALTED = 3'd5
  } estado_t;

  // Stream bytes that make up one instruction word.
  localparam int BYTES_POR_PALABRA = 4;

  // Width of the stream header byte that carries the word count.
  localparam int ANCHO_CABECERA = 8;

  // True for the states that belong to a program load (drives busy).
  function automatic logic es_carga(input estado_t st);
    logic r;
    case (st)
      ST_LEN, ST_BYTES, ST_WRITE: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the states that take bytes from the stream (drives byte_ready).
  function automatic logic acepta_byte(input estado_t st);
    logic r;
    case (st)
      ST_LEN, ST_BYTES: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/secuenciador_arranque_ensamblador.sv
// ensamblador_palabra
// Little-endian byte-to-word assembler. Each enabled byte is shifted in from
// the top so that after four bytes the first one sits in [7:0].
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   limpiar      synchronous clear of the partial word and byte counter
//   byte_en      a byte is accepted this cycle
//   byte_in      the byte being accepted
//   word_full    high in the cycle the 4th byte of a word is accepted
//   palabra      word including the byte currently presented on byte_in
module ensamblador_palabra
  import secuenciador_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        limpiar,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] palabra
);

  logic [31:0] shift_r;
  logic [1:0]  cnt_r;

  // Shift register and byte counter; the counter wraps after each word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= 32'd0;
      cnt_r   <= 2'd0;
    end else if (limpiar) begin
      shift_r <= 32'd0;
      cnt_r   <= 2'd0;
    end else if (byte_en) begin
      shift_r <= {byte_in, shift_r[31:8]};
      cnt_r   <= cnt_r + 2'd1;
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  // The full word is offered in the same cycle as its last byte so the
  // parent can register it on the edge that enters the write state.
  assign word_full = byte_en && (cnt_r == 2'(BYTES_POR_PALABRA - 1));
  assign palabra   = {byte_in, shift_r[31:8]};

endmodule

// File: rtl/secuenciador_arranque.sv
// secuenciador_arranque
// Boot and run sequencer for the single-cycle core. Holds the core in reset
// while a length-prefixed byte stream is written word by word into
// instruction memory, then releases the core on request, counts run cycles
// and re-asserts core reset on halt.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   load_req, run_req     single-cycle request pulses (load wins)
//   byte_valid/byte_data  incoming stream, byte_ready is the handshake
//   halt                  core decoded a halt instruction
//   cpu_reset             core reset, active-high
//   imem_we/addr/wdata    instruction-memory write port
//   words_loaded          words written by the last load (saturating)
//   cycles                cycles spent in RUN (wraps)
//   busy, overflow, timeout  status flags
// Optional feature: define SECUENCIADOR_WATCHDOG_EN to stop RUN after
// WDOG_CYCLES cycles and flag timeout; otherwise timeout is tied low.
module secuenciador_arranque
  import secuenciador_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WDOG_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              halt,
  output logic              cpu_reset,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       cycles,
  output logic              busy,
  output logic              overflow,
  output logic              timeout
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  estado_t state_r, state_next_s;

  logic                byte_ready_r;
  logic                imem_we_r;
  logic                cpu_reset_r;
  logic                busy_r;
  logic                overflow_r;
  logic                timeout_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [ADDR_W:0]     words_loaded_r;
  logic [31:0]         cycles_r;
  logic [ANCHO_CABECERA-1:0] n_r;
  // Index of the word being assembled; 9 bits so it can exceed any depth.
  logic [8:0]          idx_r;

  logic                acc_s;
  logic                asm_en_s;
  logic                asm_clr_s;
  logic                word_full_s;
  logic [31:0]         palabra_s;
  logic                pending_s;
  logic                ovf_word_s;
  logic                wdog_s;

  assign acc_s      = byte_valid && byte_ready_r;
  assign asm_en_s   = acc_s && (state_r == ST_BYTES);
  assign asm_clr_s  = acc_s && (state_r == ST_LEN);
  // Words past the memory depth are consumed but never written.
  assign ovf_word_s = (idx_r >= DEPTH_W);
  assign pending_s  = ((idx_r + 9'd1) < {1'b0, n_r});

  ensamblador_palabra u_ensamblador (
    .clk       (clk),
    .rst       (reset),
    .limpiar   (asm_clr_s),
    .byte_en   (asm_en_s),
    .byte_in   (byte_data),
    .word_full (word_full_s),
    .palabra   (palabra_s)
  );

`ifdef SECUENCIADOR_WATCHDOG_EN
  // Fires on the RUN edge that would bring cycles up to the limit.
  assign wdog_s = (state_r == ST_RUN) && ((cycles_r + 32'd1) == 32'(WDOG_CYCLES));
`else
  assign wdog_s = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_req) begin
          state_next_s = ST_LEN;
        end else if (run_req && (words_loaded_r != '0)) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (acc_s) begin
          if (byte_data == 8'd0) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_BYTES;
          end
        end else begin
          state_next_s = ST_LEN;
        end
      end
      ST_BYTES: begin
        if (word_full_s) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_BYTES;
        end
      end
      ST_WRITE: begin
        if (pending_s) begin
          state_next_s = ST_BYTES;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt || wdog_s) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (load_req) begin
          state_next_s = ST_LEN;
        end else if (run_req) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALTED;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register plus every registered output and load/run bookkeeping.
  // Outputs are computed from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      byte_ready_r   <= 1'b0;
      imem_we_r      <= 1'b0;
      cpu_reset_r    <= 1'b1;
      busy_r         <= 1'b0;
      overflow_r     <= 1'b0;
      addr_r         <= '0;
      wdata_r        <= 32'd0;
      words_loaded_r <= '0;
      cycles_r       <= 32'd0;
      n_r            <= '0;
      idx_r          <= 9'd0;
    end else begin
      state_r      <= state_next_s;
      byte_ready_r <= acepta_byte(state_next_s);
      busy_r       <= es_carga(state_next_s);
      cpu_reset_r  <= (state_next_s != ST_RUN);
      imem_we_r    <= (state_next_s == ST_WRITE) && !ovf_word_s;

      if (asm_clr_s) begin
        n_r            <= byte_data;
        idx_r          <= 9'd0;
        words_loaded_r <= '0;
        overflow_r     <= 1'b0;
        addr_r         <= '0;
      end else if (word_full_s) begin
        // Latch the word on entry to WRITE so it is stable during the strobe.
        if (ovf_word_s) begin
          overflow_r <= 1'b1;
        end else begin
          wdata_r <= palabra_s;
        end
      end else if (state_r == ST_WRITE) begin
        idx_r <= idx_r + 9'd1;
        if (!ovf_word_s) begin
          words_loaded_r <= words_loaded_r + 1'b1;
          addr_r         <= addr_r + 1'b1;
        end else begin
          words_loaded_r <= words_loaded_r;
        end
      end else begin
        idx_r <= idx_r;
      end

      if ((state_next_s == ST_RUN) && (state_r != ST_RUN)) begin
        cycles_r <= 32'd0;
      end else if (state_r == ST_RUN) begin
        cycles_r <= cycles_r + 32'd1;
      end else begin
        cycles_r <= cycles_r;
      end
    end
  end

`ifdef SECUENCIADOR_WATCHDOG_EN
  // Sticky timeout flag, cleared by a request accepted from HALTED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_r <= 1'b0;
    end else if (wdog_s) begin
      timeout_r <= 1'b1;
    end else if ((state_r == ST_HALTED) && (load_req || run_req)) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_r;
    end
  end
`else
  assign timeout_r = 1'b0;
`endif

  assign byte_ready   = byte_ready_r;
  assign imem_we      = imem_we_r;
  assign cpu_reset    = cpu_reset_r;
  assign busy         = busy_r;
  assign overflow     = overflow_r;
  assign timeout      = timeout_r;
  assign imem_addr    = addr_r;
  assign imem_wdata   = wdata_r;
  assign words_loaded = words_loaded_r;
  assign cycles       = cycles_r;

endmodule

// File: tb/tb_secuenciador_arranque.sv
// Directed bench for secuenciador_arranque: a 64-word instance and a 4-word
// instance share all inputs; writes, busy cycles and core-reset-low cycles
// are tallied by a posedge monitor.
module tb_secuenciador_arranque;

  localparam int AW  = 6;
  localparam int AW2 = 2;
  localparam int WD  = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req, run_req, byte_valid, halt;
  logic [7:0]  byte_data;

  logic          byte_ready, cpu_reset, imem_we, busy, overflow, timeout;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, cycles;
  logic [AW:0]   words_loaded;

  logic           byte_ready2, cpu_reset2, imem_we2, busy2, overflow2, timeout2;
  logic [AW2-1:0] imem_addr2;
  logic [31:0]    imem_wdata2, cycles2;
  logic [AW2:0]   words_loaded2;

  secuenciador_arranque #(.ADDR_W(AW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .run_req(run_req),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .halt(halt), .cpu_reset(cpu_reset), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .words_loaded(words_loaded), .cycles(cycles),
    .busy(busy), .overflow(overflow), .timeout(timeout)
  );

  secuenciador_arranque #(.ADDR_W(AW2), .WDOG_CYCLES(WD)) dut2 (
    .clk(clk), .reset(reset), .load_req(load_req), .run_req(run_req),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready2),
    .halt(halt), .cpu_reset(cpu_reset2), .imem_we(imem_we2), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .words_loaded(words_loaded2), .cycles(cycles2),
    .busy(busy2), .overflow(overflow2), .timeout(timeout2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem  [0:63];
  logic [31:0] mem2 [0:3];
  logic [31:0] ws   [0:7];
  int wr_cnt = 0, wr_cnt2 = 0, busy_cnt = 0, low_cnt = 0;

  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (imem_we2) begin
      mem2[imem_addr2] <= imem_wdata2;
      wr_cnt2 <= wr_cnt2 + 1;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (!cpu_reset) low_cnt <= low_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load;
    load_req = 1'b1; tick(); load_req = 1'b0;
  endtask

  task automatic pulse_run;
    run_req = 1'b1; tick(); run_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    byte_data  = b;
    byte_valid = 1'b1;
    w = 0;
    while (!byte_ready && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (byte_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_byte: byte_ready=%0b required 1", byte_ready);
    end
    tick();
  endtask

  task automatic stream(input int n, input bit toggle);
    int w;
    send_byte(8'(n));
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (toggle) begin
          byte_valid = 1'b0;
          tick();
        end
        send_byte(ws[k][8*j +: 8]);
      end
    end
    byte_valid = 1'b0;
    w = 0;
    while (busy && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL load_end: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; load_req = 1'b0; run_req = 1'b0; byte_valid = 1'b0;
    byte_data = 8'd0; halt = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if ({byte_ready, imem_we, cpu_reset, busy, overflow, timeout} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_flags: got %b required 001000",
               {byte_ready, imem_we, cpu_reset, busy, overflow, timeout});
    end
    total++;
    if (imem_addr !== 6'd0 || imem_wdata !== 32'd0 || words_loaded !== 7'd0 || cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_values: addr=%0d wdata=%h wl=%0d cycles=%0d required all 0",
               imem_addr, imem_wdata, words_loaded, cycles);
    end
  endtask

  task automatic test_load_basic;
    int b0, w0;
    ws[0] = 32'h00000013; ws[1] = 32'h00100093;
    b0 = busy_cnt; w0 = wr_cnt;
    pulse_load();
    stream(2, 1'b0);
    total++;
    if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL basic_writes: got %0d required 2", wr_cnt - w0); end
    total++;
    if (mem[0] !== 32'h00000013) begin bad++; $display("FAIL basic_mem0: got %h required 00000013", mem[0]); end
    total++;
    if (mem[1] !== 32'h00100093) begin bad++; $display("FAIL basic_mem1: got %h required 00100093", mem[1]); end
    total++;
    if (words_loaded !== 7'd2) begin bad++; $display("FAIL basic_wl: got %0d required 2", words_loaded); end
    total++;
    if (busy_cnt - b0 !== 11) begin bad++; $display("FAIL basic_latency: got %0d required 11", busy_cnt - b0); end
    total++;
    if (cpu_reset !== 1'b1 || imem_we !== 1'b0 || byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: cpu_reset=%0b we=%0b ready=%0b required 1 0 0", cpu_reset, imem_we, byte_ready);
    end
  endtask

  task automatic test_run_halt;
    int l0;
    l0 = low_cnt;
    pulse_run();
    total++;
    if (cpu_reset !== 1'b0) begin bad++; $display("FAIL run_release: cpu_reset=%0b required 0", cpu_reset); end
    repeat (9) tick();
    halt = 1'b1; tick(); halt = 1'b0;
    total++;
    if (cpu_reset !== 1'b1) begin bad++; $display("FAIL halt_reset: cpu_reset=%0b required 1", cpu_reset); end
    total++;
    if (cycles !== 32'd10) begin bad++; $display("FAIL halt_cycles: got %0d required 10", cycles); end
    tick(); tick();
    total++;
    if (low_cnt - l0 !== 10 || cycles !== 32'd10) begin
      bad++;
      $display("FAIL halt_frozen: low=%0d cycles=%0d required 10 10", low_cnt - l0, cycles);
    end
    pulse_run();
    total++;
    if (cycles !== 32'd0 || cpu_reset !== 1'b0) begin
      bad++;
      $display("FAIL rerun: cycles=%0d cpu_reset=%0b required 0 0", cycles, cpu_reset);
    end
    tick();
    halt = 1'b1; tick(); halt = 1'b0;
    total++;
    if (cycles !== 32'd2 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL rerun_halt: cycles=%0d cpu_reset=%0b required 2 1", cycles, cpu_reset);
    end
  endtask

  task automatic test_toggle_valid;
    int w0;
    ws[0] = 32'hDEADBEEF; ws[1] = 32'h01234567;
    w0 = wr_cnt;
    pulse_load();
    stream(2, 1'b1);
    total++;
    if (wr_cnt - w0 !== 2 || words_loaded !== 7'd2) begin
      bad++;
      $display("FAIL toggle_count: writes=%0d wl=%0d required 2 2", wr_cnt - w0, words_loaded);
    end
    total++;
    if (mem[0] !== 32'hDEADBEEF || mem[1] !== 32'h01234567) begin
      bad++;
      $display("FAIL toggle_mem: got %h %h required deadbeef 01234567", mem[0], mem[1]);
    end
  endtask

  task automatic test_overflow;
    int w0, w2, b0;
    for (int k = 0; k < 5; k++)
      ws[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
    w0 = wr_cnt; w2 = wr_cnt2; b0 = busy_cnt;
    pulse_load();
    stream(5, 1'b0);
    total++;
    if (wr_cnt2 - w2 !== 4) begin bad++; $display("FAIL ovf_writes: got %0d required 4", wr_cnt2 - w2); end
    total++;
    if (mem2[0] !== 32'h04030201 || mem2[3] !== 32'h100F0E0D) begin
      bad++;
      $display("FAIL ovf_mem: got %h %h required 04030201 100f0e0d", mem2[0], mem2[3]);
    end
    total++;
    if (overflow2 !== 1'b1 || words_loaded2 !== 3'd4) begin
      bad++;
      $display("FAIL ovf_flags: ovf=%0b wl=%0d required 1 4", overflow2, words_loaded2);
    end
    total++;
    if (overflow !== 1'b0 || words_loaded !== 7'd5 || wr_cnt - w0 !== 5 || mem[4] !== 32'h14131211) begin
      bad++;
      $display("FAIL big_load: ovf=%0b wl=%0d wr=%0d m4=%h required 0 5 5 14131211",
               overflow, words_loaded, wr_cnt - w0, mem[4]);
    end
    total++;
    if (busy_cnt - b0 !== 26) begin bad++; $display("FAIL ovf_latency: got %0d required 26", busy_cnt - b0); end
  endtask

  task automatic test_watchdog;
    pulse_run();
    repeat (60) tick();
`ifdef SECUENCIADOR_WATCHDOG_EN
    total++;
    if (cpu_reset !== 1'b1 || timeout !== 1'b1 || cycles !== 32'd50) begin
      bad++;
      $display("FAIL wdog_expire: cpu_reset=%0b timeout=%0b cycles=%0d required 1 1 50", cpu_reset, timeout, cycles);
    end
    pulse_run();
    total++;
    if (timeout !== 1'b0 || cpu_reset !== 1'b0) begin
      bad++;
      $display("FAIL wdog_clear: timeout=%0b cpu_reset=%0b required 0 0", timeout, cpu_reset);
    end
    halt = 1'b1; tick(); halt = 1'b0;
`else
    total++;
    if (cpu_reset !== 1'b0 || timeout !== 1'b0 || cycles !== 32'd60) begin
      bad++;
      $display("FAIL no_wdog: cpu_reset=%0b timeout=%0b cycles=%0d required 0 0 60", cpu_reset, timeout, cycles);
    end
    halt = 1'b1; tick(); halt = 1'b0;
    total++;
    if (cycles !== 32'd61 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL no_wdog_halt: cycles=%0d cpu_reset=%0b required 61 1", cycles, cpu_reset);
    end
`endif
  endtask

  task automatic test_priority;
    ws[0] = 32'hCAFEF00D;
    pulse_load();
    stream(1, 1'b0);
    total++;
    if (words_loaded !== 7'd1 || mem[0] !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL prio_setup: wl=%0d m0=%h required 1 cafef00d", words_loaded, mem[0]);
    end
    load_req = 1'b1; run_req = 1'b1; tick(); load_req = 1'b0; run_req = 1'b0;
    total++;
    if (byte_ready !== 1'b1 || busy !== 1'b1 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL prio_load_wins: ready=%0b busy=%0b cpu_reset=%0b required 1 1 1", byte_ready, busy, cpu_reset);
    end
    send_byte(8'd0);
    total++;
    if (busy !== 1'b0 || words_loaded !== 7'd0) begin
      bad++;
      $display("FAIL zero_len: busy=%0b wl=%0d required 0 0", busy, words_loaded);
    end
    pulse_run();
    tick();
    total++;
    if (cpu_reset !== 1'b1) begin bad++; $display("FAIL run_empty: cpu_reset=%0b required 1", cpu_reset); end
  endtask

  task automatic test_reset_midload;
    ws[0] = 32'h11223344;
    pulse_load();
    send_byte(8'd3);
    for (int j = 0; j < 4; j++) send_byte(ws[0][8*j +: 8]);
    send_byte(8'hAA);
    send_byte(8'hBB);
    total++;
    if (words_loaded !== 7'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midload_pre: wl=%0d busy=%0b required 1 1", words_loaded, busy);
    end
    byte_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (cpu_reset !== 1'b1 || words_loaded !== 7'd0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL midload_reset: cpu_reset=%0b wl=%0d busy=%0b ready=%0b required 1 0 0 0",
               cpu_reset, words_loaded, busy, byte_ready);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_run_halt();
    test_toggle_valid();
    test_overflow();
    test_watchdog();
    test_priority();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
